// File: rtl/special_case_matcher.sv
// special_case_matcher
//
// Two-stage operand-pair classifier placed in front of the MultDiv unit.
// Each accepted (A, B) pair is compared against ENTRIES masked patterns.
// The lowest-index enabled hit is reported, together with a flag that says
// whether more than one entry matched. The control path uses a hit to send
// the pair to a fixed-result path instead of the multiplier/divider.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   cfg_we/idx/field/data
//                       pattern table write port
//                       field: 0 A value, 1 A mask, 2 B value, 3 B mask,
//                              4 enable (cfg_data[0]), 5-7 no effect
//   in_valid/in_ready, in_A, in_B
//                       operand pair input
//   out_valid/out_ready, out_hit, out_idx, out_multi
//                       classification result output
//   hit_count, cnt_clr  saturating count of delivered hits, synchronous clear
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// 1. The producer holds valid and data steady until that transfer. in_ready is
// combinational from out_ready, so a full pipeline still accepts a new pair in
// the same cycle the consumer takes the oldest result.

module special_case_matcher #(
    parameter int          WIDTH     = 32,
    parameter int          ENTRIES   = 4,
    parameter int          IDX_W     = 2,
    parameter logic [31:0] ENTRY0_A  = 32'hFFFF8000,
    parameter logic [31:0] ENTRY0_B  = 32'h00010000,
    parameter bit          ENTRY0_EN = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [2:0]       cfg_field,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_hit,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_multi,
    output logic [15:0]      hit_count,
    input  logic             cnt_clr
);

    localparam logic [WIDTH-1:0] E0_A = WIDTH'(ENTRY0_A);
    localparam logic [WIDTH-1:0] E0_B = WIDTH'(ENTRY0_B);

    // Pattern table (registered) and its next-state view.
    logic [WIDTH-1:0]   aval     [ENTRIES];
    logic [WIDTH-1:0]   amask    [ENTRIES];
    logic [WIDTH-1:0]   bval     [ENTRIES];
    logic [WIDTH-1:0]   bmask    [ENTRIES];
    logic [ENTRIES-1:0] en;
    logic [WIDTH-1:0]   aval_nx  [ENTRIES];
    logic [WIDTH-1:0]   amask_nx [ENTRIES];
    logic [WIDTH-1:0]   bval_nx  [ENTRIES];
    logic [WIDTH-1:0]   bmask_nx [ENTRIES];
    logic [ENTRIES-1:0] en_nx;

    // Pipeline state.
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_adv;
    logic             s2_adv;

    logic [ENTRIES-1:0] match;
    logic               hit_c;
    logic [IDX_W-1:0]   idx_c;
    logic               multi_c;

    // Table contents after the write (if any) of this cycle. cfg_idx values
    // that name no entry never compare equal to a loop index, so they are
    // dropped without a separate range check.
    always_comb begin
        en_nx = en;
        for (int i = 0; i < ENTRIES; i++) begin
            aval_nx[i]  = aval[i];
            amask_nx[i] = amask[i];
            bval_nx[i]  = bval[i];
            bmask_nx[i] = bmask[i];
            if (cfg_we && (cfg_idx == IDX_W'(i))) begin
                case (cfg_field)
                    3'd0:    aval_nx[i]  = cfg_data;
                    3'd1:    amask_nx[i] = cfg_data;
                    3'd2:    bval_nx[i]  = cfg_data;
                    3'd3:    bmask_nx[i] = cfg_data;
                    3'd4:    en_nx[i]    = cfg_data[0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                aval[i]  <= (i == 0) ? E0_A : '0;
                amask[i] <= (i == 0) ? '1 : '0;
                bval[i]  <= (i == 0) ? E0_B : '0;
                bmask[i] <= (i == 0) ? '1 : '0;
            end
            en <= ENTRIES'(ENTRY0_EN);
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                aval[i]  <= aval_nx[i];
                amask[i] <= amask_nx[i];
                bval[i]  <= bval_nx[i];
                bmask[i] <= bmask_nx[i];
            end
            en <= en_nx;
        end
    end

    // The S1 pair is classified against the table as it stands after this
    // edge's write, so a write issued in the same cycle a stalled pair is
    // released already governs that pair's result.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            match[i] = en_nx[i]
                     & ~|((s1_a ^ aval_nx[i]) & amask_nx[i])
                     & ~|((s1_b ^ bval_nx[i]) & bmask_nx[i]);
        end
    end

    // Lowest matching index wins; any later match marks the result as multi.
    always_comb begin
        hit_c   = 1'b0;
        idx_c   = '0;
        multi_c = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (match[i]) begin
                if (hit_c) begin
                    multi_c = 1'b1;
                end else begin
                    idx_c = IDX_W'(i);
                end
                hit_c = 1'b1;
            end
        end
    end

    assign s2_adv   = !out_valid | out_ready;
    assign s1_adv   = s1_valid & s2_adv;
    assign in_ready = !s1_valid | s1_adv;

    // Stage 1: operand capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_a <= in_A;
                s1_b <= in_B;
            end
        end
    end

    // Stage 2: classification result, held while the consumer stalls.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_hit   <= 1'b0;
            out_idx   <= '0;
            out_multi <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_hit   <= hit_c;
                out_idx   <= idx_c;
                out_multi <= multi_c;
            end
        end
    end

    // Delivered-hit counter; clear wins over a simultaneous increment.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_count <= '0;
        end else if (cnt_clr) begin
            hit_count <= '0;
        end else if (out_valid && out_ready && out_hit && (hit_count != 16'hFFFF)) begin
            hit_count <= hit_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_special_case_matcher.sv
// tb_special_case_matcher
//
// Directed bench for special_case_matcher. Expected results are pushed to
// exp_q when a pair is accepted and compared when the result is delivered.
// Result encoding in the queue: {hit, idx[1:0], multi}.

module tb_special_case_matcher;

    localparam int WIDTH = 32;
    localparam int IDX_W = 2;
    localparam int W     = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             cfg_we = 1'b0;
    logic [IDX_W-1:0] cfg_idx = '0;
    logic [2:0]       cfg_field = '0;
    logic [WIDTH-1:0] cfg_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_A = '0;
    logic [WIDTH-1:0] in_B = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_hit;
    logic [IDX_W-1:0] out_idx;
    logic             out_multi;
    logic [15:0]      hit_count;
    logic             cnt_clr = 1'b0;

    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           out_hs = 0;
    bit           mon_en = 1'b1;

    special_case_matcher dut (
        .clock     (clock),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_field (cfg_field),
        .cfg_data  (cfg_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_A      (in_A),
        .in_B      (in_B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hit   (out_hit),
        .out_idx   (out_idx),
        .out_multi (out_multi),
        .hit_count (hit_count),
        .cnt_clr   (cnt_clr)
    );

    // Clock
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare each delivered result with the oldest expectation.
    always @(negedge clock) begin
        if (mon_en && reset && out_valid && out_ready) begin
            out_hs++;
            if (exp_q.size() == 0) begin
                check("out_extra", 32'(out_valid), 32'd0);
            end else begin
                check("result", 32'({out_hit, out_idx, out_multi}), 32'(exp_q.pop_front()));
            end
        end
    end

    // Drivers: all called at posedge+1.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [W-1:0] e);
        int g = 0;
        in_A = a;
        in_B = b;
        in_valid = 1'b1;
        @(negedge clock);
        while (!in_ready && g < 200) begin
            g++;
            @(negedge clock);
        end
        if (!in_ready) begin
            check("send_timeout", 32'(in_ready), 32'd1);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic cfg(input logic [IDX_W-1:0] idx, input logic [2:0] field, input logic [31:0] data);
        cfg_we = 1'b1;
        cfg_idx = idx;
        cfg_field = field;
        cfg_data = data;
        @(posedge clock); #1;
        cfg_we = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(posedge clock); #1;
            g++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) begin
            @(posedge clock); #1;
        end
    endtask

    logic [31:0]  bp_a [4];
    logic [W-1:0] bp_e [4];
    logic [4:0]   snap;
    bit           have_snap;
    int           acc;
    int           hs0;
    int           guard;
    int           sent;
    logic [31:0]  ra;

    initial begin
        // Reset
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_hit_count", 32'(hit_count), 32'd0);
        check("rst_out_hit", 32'(out_hit), 32'd0);

        // 1: default corner entry and latency
        send(32'hFFFF8000, 32'h00010000, 4'b1000);
        check("lat_first_edge", 32'(out_valid), 32'd0);
        @(posedge clock); #1;
        check("lat_second_edge", 32'(out_valid), 32'd1);
        drain();
        check("cnt_after_corner", 32'(hit_count), 32'd1);

        // 2: near miss
        send(32'hFFFF8001, 32'h00010000, 4'b0000);
        drain();
        check("cnt_after_miss", 32'(hit_count), 32'd1);

        // 3: entry 2 wildcard, entry 1 exact A
        cfg(2, 3'd1, 32'h0);
        cfg(2, 3'd3, 32'h0);
        cfg(2, 3'd4, 32'h1);
        cfg(1, 3'd0, 32'h5);
        cfg(1, 3'd1, 32'hFFFFFFFF);
        cfg(1, 3'd3, 32'h0);
        cfg(1, 3'd4, 32'h1);
        send(32'h5, 32'h7, 4'b1011);
        send(32'h6, 32'h7, 4'b1100);
        for (int k = 0; k < 8; k++) begin
            ra = 32'($urandom_range(0, 15));
            send(ra, $urandom(), (ra == 32'h5) ? 4'b1011 : 4'b1100);
        end
        drain();
        check("cnt_after_prio", 32'(hit_count), 32'd11);

        // 4: backpressure
        bp_a[0] = 32'h5;         bp_e[0] = 4'b1011;
        bp_a[1] = 32'h6;         bp_e[1] = 4'b1100;
        bp_a[2] = 32'hFFFF8000;  bp_e[2] = 4'b1001;
        bp_a[3] = 32'h9;         bp_e[3] = 4'b1100;
        hs0 = out_hs;
        out_ready = 1'b0;
        acc = 0;
        have_snap = 1'b0;
        snap = '0;
        in_valid = 1'b1;
        in_A = bp_a[0];
        in_B = 32'h00010000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (have_snap) begin
                check("bp_stable", 32'({out_valid, out_hit, out_idx, out_multi}), 32'(snap));
            end else if (out_valid) begin
                snap = {out_valid, out_hit, out_idx, out_multi};
                have_snap = 1'b1;
            end
            if (in_ready) begin
                exp_q.push_back(bp_e[acc]);
                acc++;
            end
            @(posedge clock); #1;
            if (acc < 4) in_A = bp_a[acc];
            else in_valid = 1'b0;
        end
        check("bp_accepts", 32'(acc), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_held_value", 32'(snap), 32'({1'b1, bp_e[0]}));
        out_ready = 1'b1;
        guard = 0;
        while (acc < 4 && guard < 50) begin
            @(negedge clock);
            if (in_ready) begin
                exp_q.push_back(bp_e[acc]);
                acc++;
            end
            @(posedge clock); #1;
            if (acc < 4) in_A = bp_a[acc];
            else in_valid = 1'b0;
            guard++;
        end
        in_valid = 1'b0;
        check("bp_all_sent", 32'(acc), 32'd4);
        drain();
        check("bp_out_count", 32'(out_hs - hs0), 32'd4);
        check("cnt_after_bp", 32'(hit_count), 32'd15);

        // 5: config write racing the release of a stalled pair
        cfg(2, 3'd4, 32'h0);
        cfg(3, 3'd0, 32'h33);
        cfg(3, 3'd1, 32'hFFFFFFFF);
        cfg(3, 3'd4, 32'h1);
        cfg(3, 3'd5, 32'h0);
        out_ready = 1'b0;
        send(32'h33, 32'h0, 4'b1110);
        send(32'h33, 32'h0, 4'b0000);
        check("race_stall_ready", 32'(in_ready), 32'd0);
        @(posedge clock); #1;
        check("race_s2_hold", 32'({out_valid, out_hit, out_idx, out_multi}), 32'b11110);
        out_ready = 1'b1;
        cfg_we = 1'b1;
        cfg_idx = 2'd3;
        cfg_field = 3'd4;
        cfg_data = 32'h0;
        @(posedge clock); #1;
        cfg_we = 1'b0;
        drain();
        check("cnt_after_race", 32'(hit_count), 32'd16);

        // 6: counter clear, saturation, clear-vs-increment
        cnt_clr = 1'b1;
        @(posedge clock); #1;
        cnt_clr = 1'b0;
        check("cnt_clear", 32'(hit_count), 32'd0);
        cfg(2, 3'd4, 32'h1);
        mon_en = 1'b0;
        sent = 0;
        guard = 0;
        in_A = 32'h9;
        in_B = 32'h0;
        in_valid = 1'b1;
        while (sent < 65535 && guard < 70000) begin
            @(negedge clock);
            if (in_ready) sent++;
            guard++;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clock); #1;
        end
        mon_en = 1'b1;
        check("bulk_sent", 32'(sent), 32'd65535);
        check("cnt_full", 32'(hit_count), 32'hFFFF);
        send(32'h9, 32'h0, 4'b1100);
        drain();
        check("cnt_saturate", 32'(hit_count), 32'hFFFF);
        out_ready = 1'b0;
        send(32'h9, 32'h0, 4'b1100);
        @(posedge clock); #1;
        check("clr_pair_waiting", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        cnt_clr = 1'b1;
        @(posedge clock); #1;
        cnt_clr = 1'b0;
        check("cnt_clr_priority", 32'(hit_count), 32'd0);
        drain();

        // Reset in the middle of a stream
        mon_en = 1'b0;
        in_A = 32'h9;
        in_B = 32'h0;
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
        end
        check("mid_valid_before", 32'(out_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_valid_reset", 32'(out_valid), 32'd0);
        check("mid_cnt_reset", 32'(hit_count), 32'd0);
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        exp_q.delete();
        mon_en = 1'b1;
        @(posedge clock); #1;
        send(32'hFFFF8000, 32'h00010000, 4'b1000);
        send(32'h9, 32'h0, 4'b0000);
        drain();
        check("cnt_after_reset", 32'(hit_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/special_case_matcher.md
Name: special_case_matcher

Overview:
- Pipelined, programmable operand-pair classifier for the MultDiv unit.
- Compares each incoming (A, B) operand pair against a table of ENTRIES masked patterns and reports the lowest-index hit.
- Sits in front of the multiplier/divider; the control path uses a hit to route the pair to a fixed-result path.
- Entry 0 resets to the -32768 x 65536 corner case; remaining entries are loaded at runtime. Valid/ready handshake on input and output, plus a saturating hit counter.

Parameters:
WIDTH, 32, operand width in bits
ENTRIES, 4, number of pattern entries (2..16)
IDX_W, 2, index width; must equal ceil(log2(ENTRIES))
ENTRY0_A, 32'hFFFF8000, reset value of entry 0 A pattern (A mask resets all-ones)
ENTRY0_B, 32'h00010000, reset value of entry 0 B pattern (B mask resets all-ones)
ENTRY0_EN, 1, reset value of entry 0 enable

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cfg_we  in  1  table write strobe
cfg_idx  in  IDX_W  entry to write
cfg_field  in  3  field select: 0 A value, 1 A mask, 2 B value, 3 B mask, 4 enable (cfg_data[0]); 5-7 ignored
cfg_data  in  WIDTH  write data
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept a pair
in_A  in  WIDTH  operand A
in_B  in  WIDTH  operand B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_hit  out  1  at least one enabled entry matched
out_idx  out  IDX_W  lowest matching index (0 when no hit)
out_multi  out  1  two or more entries matched
hit_count  out  16  saturating count of accepted results with out_hit=1
cnt_clr  in  1  synchronous clear of hit_count

Behaviour:
- Reset (reset=0, asynchronous):
  - Both stage valids, out_hit, out_idx, out_multi and hit_count go to 0.
  - Entry 0 loads the ENTRY0_* values. Entries 1..ENTRIES-1 load value 0, mask 0, enable 0.
  - in_ready=1 once reset is released. Reset mid-operation discards in-flight pairs.
- Match rule for entry i:
  - en[i] & (((in_A ^ Aval[i]) & Amask[i]) == 0) & (((in_B ^ Bval[i]) & Bmask[i]) == 0).
  - A mask bit of 1 means "compare this bit"; an all-zero mask is a wildcard.
- Pipeline, two stages:
  - S1 registers A and B on an input handshake (in_valid & in_ready).
  - S2 registers hit, idx and multi, computed from the S1 operands and the current table.
  - Latency is 2 cycles from input handshake to out_valid when out_ready is held 1.
  - Throughput is 1 pair per cycle.
- Handshake:
  - S2 advances when !s2_valid | out_ready.
  - S1 advances into S2 when s1_valid and S2 advances.
  - in_ready = !s1_valid | (S1 advances); this is a combinational ready path.
  - Outputs hold stable while out_valid & !out_ready. in_A and in_B are sampled only on handshake.
- Priority:
  - out_idx is the lowest matching index.
  - out_multi=1 when popcount(matches) >= 2. out_multi=0 when there is no hit.
- Config timing:
  - A write at edge N is visible to matches evaluated in the cycle after edge N.
  - A pair already captured in S2 is never re-evaluated. A pair stalled in S1 is evaluated against the table current at its transfer edge.
  - cfg_idx >= ENTRIES: write ignored.
  - Writes are allowed at any time, including during a stall.
- hit_count:
  - Increments on each output handshake with out_hit=1.
  - Saturates at 16'hFFFF.
  - cnt_clr has priority over an increment in the same cycle; the result is 0.
- WIDTH arithmetic: all comparisons are bitwise. There is no sign or extension handling; ENTRY0_* are truncated to WIDTH.

Test Plan:
1. Reset defaults: after reset, A=32'hFFFF8000, B=32'h00010000 with out_ready=1 -> 2 cycles later out_valid=1, out_hit=1, out_idx=0, out_multi=0, hit_count=1.
2. Near miss: A=32'hFFFF8001, B=32'h00010000 -> out_hit=0, out_idx=0, hit_count unchanged.
3. Multi-entry priority:
   - Write entry 2 with A mask 0, B mask 0, enable 1 (wildcard); write entry 1 with A value 5, A mask all-ones, B mask 0, enable 1.
   - A=5, B=7 -> out_hit=1, out_idx=1, out_multi=1.
   - A=6 -> out_idx=2, out_multi=0.
4. Backpressure:
   - Stream 4 pairs with in_valid=1 and out_ready=0 for 5 cycles -> in_ready drops after 2 accepts; out_* stay stable.
   - Release out_ready -> all 4 results emerge in order with no loss or duplication.
5. Config/stall race: stall a pair in S1 matching entry 3; write entry-3 enable=0 in the same cycle as release -> result out_hit=0; a pair already in S2 keeps its original result.
6. Counter and reset:
   - Preload hit_count to 16'hFFFF, then another hit -> stays 16'hFFFF.
   - cnt_clr together with a hit -> hit_count=0.
   - Assert reset mid-stream -> out_valid=0 immediately, entry 0 restored.
